// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - encodes instruction descriptors into RV32I words and writes them to instruction memory
//
// Optional feature macro: ENCODER_IMM_CHECK_EN (immediate range checking per class)
//
// Ports:
//   clk, reset           clock (rising edge), asynchronous active-high reset
//   start                one-cycle pulse, arms the loader from IDLE or DONE
//   in_valid/in_ready    descriptor handshake
//   in_class ... in_last descriptor fields (class, funct3, funct7 bit 5, rd/rs1/rs2, imm, last)
//   mem_we/addr/wdata    instruction memory write port, one word per accepted descriptor
//   busy, done, err      status: RUN/FLUSH, DONE, sticky invalid-descriptor flag
//   count                words written since start
module instr_encoder_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_class,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7b5,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] TOP  = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                err_q, err_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [31:0]         wdata_q, wdata_d;

    logic [31:0]         enc_word;
    logic                class_ok;
    logic                imm_ok;
    logic                desc_ok;

    // Combinational encoder: descriptor fields -> RV32I instruction word.
    always_comb begin
        enc_word = 32'h0;
        class_ok = 1'b1;
        case (in_class)
            4'd0: enc_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
            4'd1: enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
            4'd2: enc_word = {1'b0, in_funct7b5, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
            4'd3: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                              in_imm[4:1], in_imm[11], 7'b1100011};
            4'd4: begin
                // Shift-immediates carry funct7 in the upper bits and a 5-bit shamt.
                if (in_funct3 == 3'b001 || in_funct3 == 3'b101)
                    enc_word = {1'b0, in_funct7b5, 5'b0, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'b0010011};
                else
                    enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
            end
            4'd5: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
            4'd6: enc_word = {in_imm[31:12], in_rd, 7'b0110111};
            4'd7: enc_word = {in_imm[31:12], in_rd, 7'b0010111};
            4'd8: enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
            default: class_ok = 1'b0;
        endcase
    end

`ifdef ENCODER_IMM_CHECK_EN
    // An immediate fits in N bits when all bits from N-1 upward are identical.
    logic fit12, fit13, fit21;
    assign fit12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign fit13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    assign fit21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

    always_comb begin
        imm_ok = 1'b1;
        case (in_class)
            4'd0, 4'd1, 4'd4, 4'd8: imm_ok = fit12;
            4'd3:                   imm_ok = fit13 & ~in_imm[0];
            4'd5:                   imm_ok = fit21 & ~in_imm[0];
            4'd6, 4'd7:             imm_ok = ~(|in_imm[11:0]);
            default:                imm_ok = 1'b1;
        endcase
    end
`else
    assign imm_ok = 1'b1;
`endif

    assign desc_ok = class_ok & imm_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= BASE;
            count_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            err_q   <= err_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        err_d   = err_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    addr_d  = BASE;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            S_RUN: begin
                if (in_valid) begin
                    if (desc_ok) begin
                        we_d    = 1'b1;
                        waddr_d = addr_q;
                        wdata_d = enc_word;
                        addr_d  = addr_q + 1'b1;
                        count_d = count_q + 1'b1;
                    end else begin
                        err_d   = 1'b1;
                    end
                    // Writing the top address ends the program; there is no wrap.
                    if (in_last || (desc_ok && addr_q == TOP))
                        state_d = S_FLUSH;
                end
            end
            S_FLUSH: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready  = (state_q == S_RUN);
    assign busy      = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign count     = count_q;
    assign mem_we    = we_q;
    assign mem_addr  = waddr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - self-checking bench for instr_encoder_loader
module tb_instr_encoder_loader;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    in_class = '0;
    logic [2:0]    in_funct3 = '0;
    logic          in_funct7b5 = 1'b0;
    logic [4:0]    in_rd = '0;
    logic [4:0]    in_rs1 = '0;
    logic [4:0]    in_rs2 = '0;
    logic [31:0]   in_imm = '0;
    logic          in_last = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   count;

    int errors = 0;
    int checks = 0;

    instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoding built from field arithmetic on the descriptor.
    function automatic logic [31:0] model_enc(input logic [31:0] cls, input logic [31:0] f3,
                                              input logic [31:0] f7, input logic [31:0] rd,
                                              input logic [31:0] rs1, input logic [31:0] rs2,
                                              input logic [31:0] imm);
        logic [31:0] r;
        r = 32'h0;
        case (cls)
            32'd0: r = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (32'd2 << 12) | (rd << 7) | 32'h03;
            32'd1: r = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (32'd2 << 12)
                       | ((imm & 32'h1F) << 7) | 32'h23;
            32'd2: r = (f7 << 30) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
            32'd3: r = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
                       | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
                       | (((imm >> 11) & 32'h1) << 7) | 32'h63;
            32'd4: begin
                if (f3 == 32'd1 || f3 == 32'd5)
                    r = (f7 << 30) | ((imm & 32'h1F) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
                else
                    r = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
            end
            32'd5: r = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                       | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                       | (rd << 7) | 32'h6F;
            32'd6: r = (imm & 32'hFFFFF000) | (rd << 7) | 32'h37;
            32'd7: r = (imm & 32'hFFFFF000) | (rd << 7) | 32'h17;
            32'd8: r = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (rd << 7) | 32'h67;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    // Model state: phase 0 idle, 1 run, 2 flush, 3 done.
    int          m_phase = 0;
    int          m_count = 0;
    bit          m_err = 0;
    bit          m_we = 0;
    int          m_addr = 0;
    logic [31:0] m_data = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = 0; m_count = 0; m_err = 0; m_we = 0; m_addr = 0; m_data = 0;
        end else begin
            m_we = 0;
            if (m_phase == 0 || m_phase == 3) begin
                if (start) begin
                    m_phase = 1; m_count = 0; m_err = 0;
                end
            end else if (m_phase == 1) begin
                if (in_valid) begin
                    bit ok;
                    ok = (in_class <= 4'd8);
                    if (ok) begin
                        m_we   = 1;
                        m_addr = m_count;
                        m_data = model_enc(32'(in_class), 32'(in_funct3), 32'(in_funct7b5), 32'(in_rd),
                                           32'(in_rs1), 32'(in_rs2), in_imm);
                        m_count++;
                    end else begin
                        m_err = 1;
                    end
                    if (in_last || (ok && m_addr == (1 << AW) - 1)) m_phase = 2;
                end
            end else if (m_phase == 2) begin
                m_phase = 3;
            end
        end
    end

    always @(negedge clk) begin
        chk("mem_we", 32'(mem_we), 32'(m_we));
        if (m_we) begin
            chk("mem_addr", 32'(mem_addr), 32'(m_addr));
            chk("mem_wdata", mem_wdata, m_data);
        end
        chk("in_ready", 32'(in_ready), 32'(m_phase == 1));
        chk("busy", 32'(busy), 32'(m_phase == 1 || m_phase == 2));
        chk("done", 32'(done), 32'(m_phase == 3));
        chk("err", 32'(err), 32'(m_err));
        chk("count", 32'(count), 32'(m_count));
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Presents a descriptor and returns 1 time unit after the accepting edge.
    task automatic send(input logic [3:0] cls, input logic [2:0] f3, input logic f7,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic last);
        bit ok;
        in_class = cls; in_funct3 = f3; in_funct7b5 = f7;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
        in_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                ok = 1;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready never high (class %0d)", cls);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Single IALU addi x1, x0, 5 then a closing LW.
        pulse_start();
        send(4'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
        chk("t1_we", 32'(mem_we), 32'd1);
        chk("t1_addr", 32'(mem_addr), 32'd0);
        chk("t1_word", mem_wdata, 32'h00500093);
        chk("t1_count", 32'(count), 32'd1);
        send(4'd0, 3'd0, 1'b0, 5'd4, 5'd2, 5'd0, 32'hFFFFFFF8, 1'b1);
        idle_inputs();
        chk("t1_flush_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("t1_done", 32'(done), 32'd1);

        // SW then BRANCH with in_last.
        pulse_start();
        send(4'd1, 3'd0, 1'b0, 5'd0, 5'd0, 5'd2, 32'd8, 1'b0);
        chk("t2_sw_word", mem_wdata, 32'h00202423);
        send(4'd3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b1);
        idle_inputs();
        chk("t2_br_addr", 32'(mem_addr), 32'd1);
        chk("t2_br_word", mem_wdata, 32'hFE208EE3);
        @(posedge clk); #1;
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_count", 32'(count), 32'd2);

        // JAL then LUI back to back.
        pulse_start();
        send(4'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b0);
        chk("t3_jal_word", mem_wdata, 32'h008000EF);
        send(4'd6, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1);
        idle_inputs();
        chk("t3_lui_we", 32'(mem_we), 32'd1);
        chk("t3_lui_word", mem_wdata, 32'h123452B7);
        repeat (2) @(posedge clk); #1;

        // Invalid class between two valid descriptors; sub x3, x1, x2 closes.
        pulse_start();
        chk("t4_err_cleared", 32'(err), 32'd0);
        send(4'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
        send(4'd12, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd1, 1'b0);
        chk("t4_no_write", 32'(mem_we), 32'd0);
        send(4'd2, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
        idle_inputs();
        chk("t4_addr", 32'(mem_addr), 32'd1);
        chk("t4_word", mem_wdata, 32'h402081B3);
        chk("t4_err", 32'(err), 32'd1);
        repeat (2) @(posedge clk); #1;

        // Fill the whole 4-word memory without in_last; the fifth is refused.
        pulse_start();
        chk("t5_err_cleared", 32'(err), 32'd0);
        send(4'd0, 3'd0, 1'b0, 5'd4, 5'd2, 5'd0, 32'hFFFFFFF8, 1'b0);
        send(4'd8, 3'd0, 1'b0, 5'd0, 5'd1, 5'd0, 32'd0, 1'b0);
        send(4'd7, 3'd0, 1'b0, 5'd3, 5'd0, 5'd0, 32'h00001000, 1'b0);
        send(4'd4, 3'd5, 1'b1, 5'd2, 5'd2, 5'd0, 32'd3, 1'b0);
        chk("t5_top_addr", 32'(mem_addr), 32'd3);
        chk("t5_srai_word", mem_wdata, 32'h40315113);
        chk("t5_ready_drop", 32'(in_ready), 32'd0);
        in_class = 4'd4; in_valid = 1'b1;
        repeat (3) @(posedge clk); #1;
        idle_inputs();
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_count", 32'(count), 32'd4);

        // Reset one cycle after a handshake discards the write.
        pulse_start();
        send(4'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
        idle_inputs();
        reset = 1'b1;
        #1;
        chk("t6_we_killed", 32'(mem_we), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_count", 32'(count), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        pulse_start();
        send(4'd6, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1);
        idle_inputs();
        chk("t6_restart_addr", 32'(mem_addr), 32'd0);
        chk("t6_restart_word", mem_wdata, 32'h123452B7);
        repeat (3) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
